// File: rtl/reg_stack_arbiter_if.sv
// Port bundle between the two requesters, the arbiter and the register stack.
// The arbiter connects through the slave modport; the environment connects through master.
interface reg_stack_arbiter_if #(
    parameter int WORD_SIZE = 16,
    parameter int NIB_SIZE  = 4
);
    logic                 a_req, a_rd_en, a_wr_en;
    logic [NIB_SIZE-1:0]  a_rd_num1, a_rd_num2, a_wr_num;
    logic [WORD_SIZE-1:0] a_wr_val;
    logic                 a_grant, a_valid;
    logic [WORD_SIZE-1:0] a_rd_val1, a_rd_val2;

    logic                 b_req, b_rd_en, b_wr_en;
    logic [NIB_SIZE-1:0]  b_rd_num1, b_rd_num2, b_wr_num;
    logic [WORD_SIZE-1:0] b_wr_val;
    logic                 b_grant, b_valid;
    logic [WORD_SIZE-1:0] b_rd_val1, b_rd_val2;

    logic [NIB_SIZE-1:0]  rs_num1, rs_num2, rs_setnum;
    logic [WORD_SIZE-1:0] rs_setval;
    logic                 rs_get_enable, rs_set_enable;
    logic [WORD_SIZE-1:0] rs_out1, rs_out2;

    modport slave (
        input  a_req, a_rd_en, a_rd_num1, a_rd_num2, a_wr_en, a_wr_num, a_wr_val,
        output a_grant, a_valid, a_rd_val1, a_rd_val2,
        input  b_req, b_rd_en, b_rd_num1, b_rd_num2, b_wr_en, b_wr_num, b_wr_val,
        output b_grant, b_valid, b_rd_val1, b_rd_val2,
        output rs_num1, rs_num2, rs_setnum, rs_setval, rs_get_enable, rs_set_enable,
        input  rs_out1, rs_out2
    );

    modport master (
        output a_req, a_rd_en, a_rd_num1, a_rd_num2, a_wr_en, a_wr_num, a_wr_val,
        input  a_grant, a_valid, a_rd_val1, a_rd_val2,
        output b_req, b_rd_en, b_rd_num1, b_rd_num2, b_wr_en, b_wr_num, b_wr_val,
        input  b_grant, b_valid, b_rd_val1, b_rd_val2,
        input  rs_num1, rs_num2, rs_setnum, rs_setval, rs_get_enable, rs_set_enable,
        output rs_out1, rs_out2
    );
endinterface

// File: rtl/reg_stack_arbiter.sv
// Round-robin arbiter sharing the register stack access path between ports A and B.
// One transaction per cycle; read results return to the owner two edges after sampling.
module reg_stack_arbiter #(
    parameter int WORD_SIZE = 16,
    parameter int NIB_SIZE  = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    reg_stack_arbiter_if.slave bus
);
    typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

    typedef struct packed {
        logic                 rd_en;
        logic [NIB_SIZE-1:0]  rd_num1;
        logic [NIB_SIZE-1:0]  rd_num2;
        logic                 wr_en;
        logic [NIB_SIZE-1:0]  wr_num;
        logic [WORD_SIZE-1:0] wr_val;
    } txn_t;

    typedef struct packed {
        logic  pending;
        port_e owner;
    } tag_t;

    txn_t a_txn, b_txn, win_txn;
    logic grant_a, grant_b;

    port_e                last_winner_q, last_winner_d;
    logic                 a_grant_q, a_grant_d;
    logic                 b_grant_q, b_grant_d;
    logic                 rs_get_en_q, rs_get_en_d;
    logic                 rs_set_en_q, rs_set_en_d;
    logic [NIB_SIZE-1:0]  rs_num1_q, rs_num1_d;
    logic [NIB_SIZE-1:0]  rs_num2_q, rs_num2_d;
    logic [NIB_SIZE-1:0]  rs_setnum_q, rs_setnum_d;
    logic [WORD_SIZE-1:0] rs_setval_q, rs_setval_d;
    tag_t                 tag1_q, tag1_d;
    tag_t                 tag2_q, tag2_d;

    always_comb begin
        a_txn = '{rd_en: bus.a_rd_en, rd_num1: bus.a_rd_num1, rd_num2: bus.a_rd_num2,
                  wr_en: bus.a_wr_en, wr_num: bus.a_wr_num, wr_val: bus.a_wr_val};
        b_txn = '{rd_en: bus.b_rd_en, rd_num1: bus.b_rd_num1, rd_num2: bus.b_rd_num2,
                  wr_en: bus.b_wr_en, wr_num: bus.b_wr_num, wr_val: bus.b_wr_val};
    end

    // A wins unless B is also asking and A took the previous grant.
    always_comb begin
        grant_a = bus.a_req && (!bus.b_req || last_winner_q == PORT_B);
        grant_b = bus.b_req && !grant_a;
        win_txn = grant_a ? a_txn : b_txn;
    end

    always_comb begin
        last_winner_d = last_winner_q;
        a_grant_d     = grant_a;
        b_grant_d     = grant_b;
        rs_get_en_d   = 1'b0;
        rs_set_en_d   = 1'b0;
        rs_num1_d     = rs_num1_q;
        rs_num2_d     = rs_num2_q;
        rs_setnum_d   = rs_setnum_q;
        rs_setval_d   = rs_setval_q;
        tag1_d        = '0;
        tag2_d        = tag1_q;
        if (grant_a || grant_b) begin
            last_winner_d = grant_a ? PORT_A : PORT_B;
            rs_get_en_d   = win_txn.rd_en;
            rs_set_en_d   = win_txn.wr_en;
            rs_num1_d     = win_txn.rd_num1;
            rs_num2_d     = win_txn.rd_num2;
            rs_setnum_d   = win_txn.wr_num;
            rs_setval_d   = win_txn.wr_val;
            tag1_d        = '{pending: win_txn.rd_en, owner: last_winner_d};
        end
    end

    // Async clear drops rs_set_enable at once so a write in flight never lands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_winner_q <= PORT_B;
            a_grant_q     <= 1'b0;
            b_grant_q     <= 1'b0;
            rs_get_en_q   <= 1'b0;
            rs_set_en_q   <= 1'b0;
            rs_num1_q     <= '0;
            rs_num2_q     <= '0;
            rs_setnum_q   <= '0;
            rs_setval_q   <= '0;
            tag1_q        <= '0;
            tag2_q        <= '0;
        end else begin
            last_winner_q <= last_winner_d;
            a_grant_q     <= a_grant_d;
            b_grant_q     <= b_grant_d;
            rs_get_en_q   <= rs_get_en_d;
            rs_set_en_q   <= rs_set_en_d;
            rs_num1_q     <= rs_num1_d;
            rs_num2_q     <= rs_num2_d;
            rs_setnum_q   <= rs_setnum_d;
            rs_setval_q   <= rs_setval_d;
            tag1_q        <= tag1_d;
            tag2_q        <= tag2_d;
        end
    end

    logic a_valid, b_valid;

    always_comb begin
        a_valid = tag2_q.pending && (tag2_q.owner == PORT_A);
        b_valid = tag2_q.pending && (tag2_q.owner == PORT_B);
    end

    assign bus.a_grant       = a_grant_q;
    assign bus.b_grant       = b_grant_q;
    assign bus.a_valid       = a_valid;
    assign bus.b_valid       = b_valid;
    assign bus.a_rd_val1     = a_valid ? bus.rs_out1 : '0;
    assign bus.a_rd_val2     = a_valid ? bus.rs_out2 : '0;
    assign bus.b_rd_val1     = b_valid ? bus.rs_out1 : '0;
    assign bus.b_rd_val2     = b_valid ? bus.rs_out2 : '0;
    assign bus.rs_get_enable = rs_get_en_q;
    assign bus.rs_set_enable = rs_set_en_q;
    assign bus.rs_num1       = rs_num1_q;
    assign bus.rs_num2       = rs_num2_q;
    assign bus.rs_setnum     = rs_setnum_q;
    assign bus.rs_setval     = rs_setval_q;
endmodule

// File: tb/tb_reg_stack_arbiter.sv
// Directed bench for reg_stack_arbiter with a behavioural register stack
// (synchronous read and write on the same edge; read sees the pre-write value).
module tb_reg_stack_arbiter;
    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    reg_stack_arbiter_if ifc ();

    reg_stack_arbiter dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] regs [16];

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = 16'hA000 | 16'(i);
        ifc.rs_out1 = '0;
        ifc.rs_out2 = '0;
        forever begin
            @(posedge clk);
            if (ifc.rs_get_enable) begin
                ifc.rs_out1 <= regs[ifc.rs_num1];
                ifc.rs_out2 <= regs[ifc.rs_num2];
            end
            if (ifc.rs_set_enable) regs[ifc.rs_setnum] <= ifc.rs_setval;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic req, input logic rd, input logic [3:0] n1, input logic [3:0] n2,
                         input logic wr, input logic [3:0] wn, input logic [15:0] wv);
        ifc.a_req = req; ifc.a_rd_en = rd; ifc.a_rd_num1 = n1; ifc.a_rd_num2 = n2;
        ifc.a_wr_en = wr; ifc.a_wr_num = wn; ifc.a_wr_val = wv;
    endtask

    task automatic set_b(input logic req, input logic rd, input logic [3:0] n1, input logic [3:0] n2,
                         input logic wr, input logic [3:0] wn, input logic [15:0] wv);
        ifc.b_req = req; ifc.b_rd_en = rd; ifc.b_rd_num1 = n1; ifc.b_rd_num2 = n2;
        ifc.b_wr_en = wr; ifc.b_wr_num = wn; ifc.b_wr_val = wv;
    endtask

    task automatic clear_inputs();
        set_a(0, 0, 0, 0, 0, 0, 16'h0);
        set_b(0, 0, 0, 0, 0, 0, 16'h0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [5:0]  ctl;
        logic [27:0] ctl_data;
        logic [63:0] rdv;
        reset_n = 1'b0;
        clear_inputs();
        tick();
        ctl = {ifc.a_grant, ifc.b_grant, ifc.a_valid, ifc.b_valid, ifc.rs_get_enable, ifc.rs_set_enable};
        n_tests++;
        if (ctl !== 6'b0) begin n_fail++; $display("FAIL reset_ctl: got %b want 000000", ctl); end
        ctl_data = {ifc.rs_num1, ifc.rs_num2, ifc.rs_setnum, ifc.rs_setval};
        n_tests++;
        if (ctl_data !== 28'h0) begin n_fail++; $display("FAIL reset_rs_fields: got %h want 0", ctl_data); end
        rdv = {ifc.a_rd_val1, ifc.a_rd_val2, ifc.b_rd_val1, ifc.b_rd_val2};
        n_tests++;
        if (rdv !== 64'h0) begin n_fail++; $display("FAIL reset_rd_vals: got %h want 0", rdv); end
        reset_n = 1'b1;
    endtask

    task automatic test_write_read();
        set_a(1, 0, 0, 0, 1, 3, 16'h1234);
        tick();
        n_tests++;
        if ({ifc.a_grant, ifc.b_grant, ifc.rs_get_enable, ifc.rs_set_enable} !== 4'b1001) begin
            n_fail++; $display("FAIL wr_ctl: got %b want 1001",
                {ifc.a_grant, ifc.b_grant, ifc.rs_get_enable, ifc.rs_set_enable});
        end
        n_tests++;
        if ({ifc.rs_setnum, ifc.rs_setval} !== 20'h31234) begin
            n_fail++; $display("FAIL wr_fields: got %h want 31234", {ifc.rs_setnum, ifc.rs_setval});
        end
        set_a(1, 1, 3, 3, 0, 0, 16'h0);
        tick();
        n_tests++;
        if ({ifc.a_grant, ifc.rs_get_enable, ifc.rs_set_enable, ifc.a_valid} !== 4'b1100) begin
            n_fail++; $display("FAIL rd_ctl: got %b want 1100",
                {ifc.a_grant, ifc.rs_get_enable, ifc.rs_set_enable, ifc.a_valid});
        end
        n_tests++;
        if ({ifc.rs_num1, ifc.rs_num2} !== 8'h33) begin
            n_fail++; $display("FAIL rd_nums: got %h want 33", {ifc.rs_num1, ifc.rs_num2});
        end
        set_a(0, 0, 0, 0, 0, 0, 16'h0);
        tick();
        n_tests++;
        if ({ifc.a_grant, ifc.a_valid, ifc.b_valid} !== 3'b010) begin
            n_fail++; $display("FAIL rd_valid: got %b want 010", {ifc.a_grant, ifc.a_valid, ifc.b_valid});
        end
        n_tests++;
        if ({ifc.a_rd_val1, ifc.a_rd_val2} !== 32'h1234_1234) begin
            n_fail++; $display("FAIL rd_data: got %h want 12341234", {ifc.a_rd_val1, ifc.a_rd_val2});
        end
        tick();
        n_tests++;
        if ({ifc.a_valid, ifc.a_rd_val1} !== 17'h0) begin
            n_fail++; $display("FAIL rd_valid_pulse: got %h want 0", {ifc.a_valid, ifc.a_rd_val1});
        end
    endtask

    task automatic test_round_robin();
        logic ea_g, eb_g, ea_v, eb_v;
        do_reset();
        set_a(1, 1, 3, 4, 0, 0, 16'h0);
        set_b(1, 1, 4, 3, 0, 0, 16'h0);
        for (int k = 0; k < 6; k++) begin
            if (k == 4) clear_inputs();
            tick();
            ea_g = (k < 4) && (k % 2 == 0);
            eb_g = (k < 4) && (k % 2 == 1);
            ea_v = (k >= 1) && (k <= 4) && ((k - 1) % 2 == 0);
            eb_v = (k >= 1) && (k <= 4) && ((k - 1) % 2 == 1);
            n_tests++;
            if ({ifc.a_grant, ifc.b_grant, ifc.a_valid, ifc.b_valid} !== {ea_g, eb_g, ea_v, eb_v}) begin
                n_fail++; $display("FAIL rr_cycle%0d: got %b want %b", k,
                    {ifc.a_grant, ifc.b_grant, ifc.a_valid, ifc.b_valid}, {ea_g, eb_g, ea_v, eb_v});
            end
            n_tests++;
            if ({ifc.a_rd_val1, ifc.a_rd_val2} !== (ea_v ? 32'h1234_A004 : 32'h0)) begin
                n_fail++; $display("FAIL rr_a_data%0d: got %h want %h", k,
                    {ifc.a_rd_val1, ifc.a_rd_val2}, (ea_v ? 32'h1234_A004 : 32'h0));
            end
            n_tests++;
            if ({ifc.b_rd_val1, ifc.b_rd_val2} !== (eb_v ? 32'hA004_1234 : 32'h0)) begin
                n_fail++; $display("FAIL rr_b_data%0d: got %h want %h", k,
                    {ifc.b_rd_val1, ifc.b_rd_val2}, (eb_v ? 32'hA004_1234 : 32'h0));
            end
        end
    endtask

    task automatic test_same_reg_rw();
        set_a(1, 0, 0, 0, 1, 5, 16'h0002);
        tick();
        set_a(1, 1, 5, 5, 1, 5, 16'h0007);
        tick();
        n_tests++;
        if ({ifc.a_grant, ifc.a_valid, ifc.rs_get_enable, ifc.rs_set_enable} !== 4'b1011) begin
            n_fail++; $display("FAIL rw_ctl: got %b want 1011",
                {ifc.a_grant, ifc.a_valid, ifc.rs_get_enable, ifc.rs_set_enable});
        end
        set_a(1, 1, 5, 5, 0, 0, 16'h0);
        tick();
        n_tests++;
        if ({ifc.a_valid, ifc.a_rd_val1, ifc.a_rd_val2} !== {1'b1, 32'h0002_0002}) begin
            n_fail++; $display("FAIL rw_old_value: got %h want 100020002",
                {ifc.a_valid, ifc.a_rd_val1, ifc.a_rd_val2});
        end
        clear_inputs();
        tick();
        n_tests++;
        if ({ifc.a_valid, ifc.a_rd_val1, ifc.a_rd_val2} !== {1'b1, 32'h0007_0007}) begin
            n_fail++; $display("FAIL rw_new_value: got %h want 100070007",
                {ifc.a_valid, ifc.a_rd_val1, ifc.a_rd_val2});
        end
        tick();
        n_tests++;
        if (ifc.a_valid !== 1'b0) begin n_fail++; $display("FAIL rw_valid_end: got %b want 0", ifc.a_valid); end
    endtask

    task automatic test_write_only_b();
        set_b(1, 0, 0, 0, 1, 1, 16'h0009);
        tick();
        n_tests++;
        if ({ifc.b_grant, ifc.a_grant, ifc.rs_get_enable, ifc.rs_set_enable} !== 4'b1001) begin
            n_fail++; $display("FAIL bw_ctl: got %b want 1001",
                {ifc.b_grant, ifc.a_grant, ifc.rs_get_enable, ifc.rs_set_enable});
        end
        n_tests++;
        if ({ifc.rs_setnum, ifc.rs_setval} !== 20'h10009) begin
            n_fail++; $display("FAIL bw_fields: got %h want 10009", {ifc.rs_setnum, ifc.rs_setval});
        end
        clear_inputs();
        for (int k = 0; k < 2; k++) begin
            tick();
            n_tests++;
            if ({ifc.b_grant, ifc.b_valid, ifc.a_valid} !== 3'b000) begin
                n_fail++; $display("FAIL bw_no_valid%0d: got %b want 000", k,
                    {ifc.b_grant, ifc.b_valid, ifc.a_valid});
            end
        end
        set_a(1, 1, 1, 1, 0, 0, 16'h0);
        tick();
        clear_inputs();
        tick();
        n_tests++;
        if ({ifc.a_valid, ifc.a_rd_val1} !== {1'b1, 16'h0009}) begin
            n_fail++; $display("FAIL bw_readback: got %h want 10009", {ifc.a_valid, ifc.a_rd_val1});
        end
        tick();
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        set_a(1, 1, 6, 6, 1, 6, 16'h5555);
        tick();
        n_tests++;
        if ({ifc.a_grant, ifc.rs_set_enable} !== 2'b11) begin
            n_fail++; $display("FAIL rst_pre: got %b want 11", {ifc.a_grant, ifc.rs_set_enable});
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({ifc.a_grant, ifc.rs_set_enable, ifc.rs_get_enable} !== 3'b000) begin
            n_fail++; $display("FAIL rst_async_ctl: got %b want 000",
                {ifc.a_grant, ifc.rs_set_enable, ifc.rs_get_enable});
        end
        n_tests++;
        if ({ifc.rs_setnum, ifc.rs_setval} !== 20'h0) begin
            n_fail++; $display("FAIL rst_async_fields: got %h want 0", {ifc.rs_setnum, ifc.rs_setval});
        end
        clear_inputs();
        tick();
        n_tests++;
        if ({ifc.a_valid, ifc.b_valid} !== 2'b00) begin
            n_fail++; $display("FAIL rst_tag_drop: got %b want 00", {ifc.a_valid, ifc.b_valid});
        end
        reset_n = 1'b1;
        set_a(1, 1, 6, 6, 0, 0, 16'h0);
        set_b(1, 1, 6, 6, 0, 0, 16'h0);
        tick();
        n_tests++;
        if ({ifc.a_grant, ifc.b_grant, ifc.a_valid} !== 3'b100) begin
            n_fail++; $display("FAIL rst_first_tie: got %b want 100", {ifc.a_grant, ifc.b_grant, ifc.a_valid});
        end
        clear_inputs();
        tick();
        n_tests++;
        if ({ifc.a_valid, ifc.b_valid, ifc.a_rd_val1} !== {2'b10, 16'hA006}) begin
            n_fail++; $display("FAIL rst_reg_unchanged: got %h want 2a006",
                {ifc.a_valid, ifc.b_valid, ifc.a_rd_val1});
        end
        tick();
    endtask

    task automatic test_withdraw();
        set_a(1, 1, 3, 3, 0, 0, 16'h0);
        set_b(1, 1, 4, 4, 0, 0, 16'h0);
        tick();
        n_tests++;
        if ({ifc.a_grant, ifc.b_grant} !== 2'b01) begin
            n_fail++; $display("FAIL wd_b_wins: got %b want 01", {ifc.a_grant, ifc.b_grant});
        end
        clear_inputs();
        tick();
        n_tests++;
        if ({ifc.a_grant, ifc.a_valid, ifc.b_valid, ifc.b_rd_val1} !== {3'b001, 16'hA004}) begin
            n_fail++; $display("FAIL wd_b_result: got %h want 1a004",
                {ifc.a_grant, ifc.a_valid, ifc.b_valid, ifc.b_rd_val1});
        end
        tick();
        n_tests++;
        if ({ifc.a_grant, ifc.a_valid} !== 2'b00) begin
            n_fail++; $display("FAIL wd_a_quiet: got %b want 00", {ifc.a_grant, ifc.a_valid});
        end
        set_a(1, 1, 3, 3, 0, 0, 16'h0);
        set_b(1, 1, 4, 4, 0, 0, 16'h0);
        tick();
        n_tests++;
        if ({ifc.a_grant, ifc.b_grant} !== 2'b10) begin
            n_fail++; $display("FAIL wd_next_tie: got %b want 10", {ifc.a_grant, ifc.b_grant});
        end
        clear_inputs();
        tick();
        n_tests++;
        if ({ifc.a_valid, ifc.b_valid, ifc.a_rd_val1} !== {2'b10, 16'h1234}) begin
            n_fail++; $display("FAIL wd_a_result: got %h want 21234",
                {ifc.a_valid, ifc.b_valid, ifc.a_rd_val1});
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        clear_inputs();
        test_reset();
        test_write_read();
        test_round_robin();
        test_same_reg_rw();
        test_write_only_b();
        test_reset_mid_write();
        test_withdraw();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
